ec_control_unit: RTL and testbench

- Moore/Mealy FSM that sequences the 8-bit accumulator datapath: PC, IR, 32x8 RAM and accumulator A.
- Reads the opcode field IR[7:5] and the A status flags.
- Drives every datapath control strobe, plus a keyboard-style input handshake and halt/debug indications.
- Sits between the top-level board wrapper and the datapath. It is the only source of datapath control.

---
 rtl/ec_control_unit_if.sv | 38 +++
 rtl/ec_control_unit.sv | 203 ++++++++++++++++++++
 tb/tb_ec_control_unit.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/ec_control_unit_if.sv
// Control/status bundle between the accumulator-machine control unit and its datapath.
// The master side (control unit) drives the strobes and status; the slave side drives opcode and flags.
interface ec_control_unit_if #(
    parameter int unsigned CNT_W = 8
) ();

    logic [2:0]       IR75;
    logic             Aeq0;
    logic             Apos;
    logic             enter;

    logic             IRload;
    logic             JMPmux;
    logic             PCload;
    logic             Meminst;
    logic             MemWr;
    logic [1:0]       Asel;
    logic             Aload;
    logic             Sub;

    logic             waiting;
    logic             halted;
    logic [3:0]       state_dbg;
    logic [CNT_W-1:0] inst_cnt;

    modport master (
        input  IR75, Aeq0, Apos, enter,
        output IRload, JMPmux, PCload, Meminst, MemWr, Asel, Aload, Sub,
        output waiting, halted, state_dbg, inst_cnt
    );

    modport slave (
        output IR75, Aeq0, Apos, enter,
        input  IRload, JMPmux, PCload, Meminst, MemWr, Asel, Aload, Sub,
        input  waiting, halted, state_dbg, inst_cnt
    );

endinterface

// File: rtl/ec_control_unit.sv
// Sequencer for the 8-bit accumulator machine: fetch/decode/execute FSM driving all
// datapath strobes, with an armed input handshake and a saturating retired-instruction counter.
module ec_control_unit #(
    parameter int unsigned CNT_W        = 8,
    parameter int unsigned START_CYCLES = 1
) (
    input  logic               clk,
    input  logic               clear,
    ec_control_unit_if.master  bus
);

    localparam int unsigned START_W = 4;
    localparam logic [START_W-1:0] START_LAST = START_W'(START_CYCLES - 1);

    localparam logic [1:0] ASEL_ALU  = 2'b00;
    localparam logic [1:0] ASEL_IN   = 2'b01;
    localparam logic [1:0] ASEL_RAM  = 2'b10;

    typedef enum logic [3:0] {
        S_START  = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_LOAD   = 4'd3,
        S_STORE  = 4'd4,
        S_ADD    = 4'd5,
        S_SUB    = 4'd6,
        S_INPUT  = 4'd7,
        S_JZ     = 4'd8,
        S_JPOS   = 4'd9,
        S_HALT   = 4'd10
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [START_W-1:0] start_cnt;
    logic               enter_armed;
    logic [CNT_W-1:0]   cnt;

    logic               irload_c;
    logic               jmpmux_c;
    logic               pcload_c;
    logic               meminst_c;
    logic               memwr_c;
    logic [1:0]         asel_c;
    logic               aload_c;
    logic               sub_c;
    logic               waiting_c;
    logic               halted_c;
    logic               capture_c;
    logic               retire_c;

    // State register; reset forces START so every strobe drops without a clock.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state <= S_START;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and per-state strobes (Mealy terms only in INPUT, JZ, JPOS).
    always_comb begin
        state_nxt = state;
        irload_c  = 1'b0;
        jmpmux_c  = 1'b0;
        pcload_c  = 1'b0;
        meminst_c = 1'b0;
        memwr_c   = 1'b0;
        asel_c    = ASEL_ALU;
        aload_c   = 1'b0;
        sub_c     = 1'b0;
        waiting_c = 1'b0;
        halted_c  = 1'b0;
        capture_c = 1'b0;
        retire_c  = 1'b0;

        case (state)
            S_START: begin
                if (start_cnt == START_LAST) begin
                    state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                irload_c  = 1'b1;
                pcload_c  = 1'b1;
                state_nxt = S_DECODE;
            end
            S_DECODE: begin
                meminst_c = 1'b1;
                case (bus.IR75)
                    3'd0:    state_nxt = S_LOAD;
                    3'd1:    state_nxt = S_STORE;
                    3'd2:    state_nxt = S_ADD;
                    3'd3:    state_nxt = S_SUB;
                    3'd4:    state_nxt = S_INPUT;
                    3'd5:    state_nxt = S_JZ;
                    3'd6:    state_nxt = S_JPOS;
                    default: state_nxt = S_HALT;
                endcase
            end
            S_LOAD: begin
                meminst_c = 1'b1;
                asel_c    = ASEL_RAM;
                aload_c   = 1'b1;
                retire_c  = 1'b1;
                state_nxt = S_FETCH;
            end
            S_STORE: begin
                meminst_c = 1'b1;
                memwr_c   = 1'b1;
                retire_c  = 1'b1;
                state_nxt = S_FETCH;
            end
            S_ADD: begin
                meminst_c = 1'b1;
                aload_c   = 1'b1;
                retire_c  = 1'b1;
                state_nxt = S_FETCH;
            end
            S_SUB: begin
                meminst_c = 1'b1;
                aload_c   = 1'b1;
                sub_c     = 1'b1;
                retire_c  = 1'b1;
                state_nxt = S_FETCH;
            end
            S_INPUT: begin
                waiting_c = 1'b1;
                asel_c    = ASEL_IN;
                // Only a fresh rising enter captures; a level held from before is ignored.
                if (bus.enter && enter_armed) begin
                    aload_c   = 1'b1;
                    capture_c = 1'b1;
                    retire_c  = 1'b1;
                    state_nxt = S_FETCH;
                end
            end
            S_JZ: begin
                jmpmux_c  = bus.Aeq0;
                pcload_c  = bus.Aeq0;
                retire_c  = 1'b1;
                state_nxt = S_FETCH;
            end
            S_JPOS: begin
                jmpmux_c  = bus.Apos & ~bus.Aeq0;
                pcload_c  = bus.Apos & ~bus.Aeq0;
                retire_c  = 1'b1;
                state_nxt = S_FETCH;
            end
            S_HALT: begin
                halted_c  = 1'b1;
            end
            default: begin
                state_nxt = S_START;
            end
        endcase
    end

    // Idle counter for the post-reset START window.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            start_cnt <= '0;
        end else if (state == S_START) begin
            start_cnt <= start_cnt + START_W'(1);
        end else begin
            start_cnt <= '0;
        end
    end

    // Input handshake: arm on a low enter, disarm on the capture cycle.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            enter_armed <= 1'b0;
        end else if (capture_c) begin
            enter_armed <= 1'b0;
        end else if (!bus.enter) begin
            enter_armed <= 1'b1;
        end
    end

    // Saturating retired-instruction counter.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            cnt <= '0;
        end else if (retire_c && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign bus.IRload    = irload_c;
    assign bus.JMPmux    = jmpmux_c;
    assign bus.PCload    = pcload_c;
    assign bus.Meminst   = meminst_c;
    assign bus.MemWr     = memwr_c;
    assign bus.Asel      = asel_c;
    assign bus.Aload     = aload_c;
    assign bus.Sub       = sub_c;
    assign bus.waiting   = waiting_c;
    assign bus.halted    = halted_c;
    assign bus.state_dbg = state;
    assign bus.inst_cnt  = cnt;

endmodule

// File: tb/tb_ec_control_unit.sv
// Bench for ec_control_unit: an instruction-level reference model checked every cycle,
// plus directed literal expectations at the key points of each instruction type.
module tb_ec_control_unit;

    localparam int unsigned CNT_W        = 8;
    localparam int unsigned START_CYCLES = 1;

    logic clk;
    logic clear;

    ec_control_unit_if #(.CNT_W(CNT_W)) bus ();

    ec_control_unit #(
        .CNT_W        (CNT_W),
        .START_CYCLES (START_CYCLES)
    ) dut (
        .clk   (clk),
        .clear (clear),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: phase 0=start idle, 1=fetch, 2=decode, 3=execute of m_op.
    int m_phase = 0;
    int m_wait  = 0;
    int m_op    = 0;
    bit m_armed = 1'b0;
    int m_cnt   = 0;

    function automatic bit m_fire();
        return (m_phase == 3) && (m_op == 4) && bus.enter && m_armed;
    endfunction

    function automatic bit m_retire();
        return ((m_phase == 3) && (m_op inside {0, 1, 2, 3, 5, 6})) || m_fire();
    endfunction

    always @(posedge clk or negedge clear) begin
        if (!clear) begin
            m_phase <= 0;
            m_wait  <= 0;
            m_op    <= 0;
            m_armed <= 1'b0;
            m_cnt   <= 0;
        end else begin
            if (m_retire() && (m_cnt < 255)) m_cnt <= m_cnt + 1;
            if (m_fire()) m_armed <= 1'b0;
            else if (!bus.enter) m_armed <= 1'b1;
            case (m_phase)
                0: begin
                    if (m_wait + 1 >= START_CYCLES) begin
                        m_phase <= 1;
                        m_wait  <= 0;
                    end else begin
                        m_wait <= m_wait + 1;
                    end
                end
                1: m_phase <= 2;
                2: begin
                    m_op    <= int'(bus.IR75);
                    m_phase <= 3;
                end
                default: begin
                    if (m_op == 7) m_phase <= 3;
                    else if (m_op == 4 && !m_fire()) m_phase <= 3;
                    else m_phase <= 1;
                end
            endcase
        end
    end

    // Expected outputs, packed as {IRload,JMPmux,PCload,Meminst,MemWr,Asel,Aload,Sub,waiting,halted,state_dbg,inst_cnt}.
    function automatic logic [22:0] model_out();
        logic irl, jmp, pcl, mi, mw, al, sb, wt, hl;
        logic [1:0] as;
        logic [3:0] st;
        logic take;
        irl = 0; jmp = 0; pcl = 0; mi = 0; mw = 0; al = 0; sb = 0; wt = 0; hl = 0;
        as = 2'b00; st = 4'd0; take = 0;
        case (m_phase)
            1: begin st = 4'd1; irl = 1; pcl = 1; end
            2: begin st = 4'd2; mi = 1; end
            3: begin
                st = 4'(3 + m_op);
                case (m_op)
                    0: begin mi = 1; as = 2'b10; al = 1; end
                    1: begin mi = 1; mw = 1; end
                    2: begin mi = 1; al = 1; end
                    3: begin mi = 1; al = 1; sb = 1; end
                    4: begin wt = 1; as = 2'b01; al = m_fire(); end
                    5: begin take = bus.Aeq0; jmp = take; pcl = take; end
                    6: begin take = bus.Apos && !bus.Aeq0; jmp = take; pcl = take; end
                    default: hl = 1;
                endcase
            end
            default: st = 4'd0;
        endcase
        return {irl, jmp, pcl, mi, mw, as, al, sb, wt, hl, st, 8'(m_cnt)};
    endfunction

    function automatic logic [22:0] dut_out();
        return {bus.IRload, bus.JMPmux, bus.PCload, bus.Meminst, bus.MemWr, bus.Asel,
                bus.Aload, bus.Sub, bus.waiting, bus.halted, bus.state_dbg, bus.inst_cnt};
    endfunction

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        logic [22:0] act;
        logic [22:0] exp;
        act = dut_out();
        exp = model_out();
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL cycle_model t=%0t got=%h expected=%h", $time, act, exp);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s t=%0t got=%h expected=%h", name, $time, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        clear     = 1'b0;
        bus.IR75  = 3'd4;
        bus.Aeq0  = 1'b0;
        bus.Apos  = 1'b0;
        bus.enter = 1'b1;

        // Reset and release into fetch/decode of an INPUT with enter held high.
        tick(2);
        chk("reset_state", 32'(bus.state_dbg), 32'd0);
        chk("reset_outputs", 32'(dut_out()), 32'd0);
        clear = 1'b1;
        tick(1);
        chk("fetch_state", 32'(bus.state_dbg), 32'd1);
        chk("fetch_strobes", 32'({bus.IRload, bus.PCload, bus.Meminst, bus.JMPmux}), 32'b1100);
        tick(1);
        chk("decode_state", 32'(bus.state_dbg), 32'd2);
        chk("decode_strobes", 32'({bus.IRload, bus.PCload, bus.MemWr, bus.Aload, bus.Sub}), 32'd0);
        tick(1);
        chk("input_wait", 32'({bus.state_dbg, bus.waiting}), 32'({4'd7, 1'b1}));
        tick(3);
        chk("input_unarmed", 32'({bus.state_dbg, bus.Aload}), 32'({4'd7, 1'b0}));
        bus.enter = 1'b0;
        tick(1);
        bus.enter = 1'b1;
        #1;
        chk("input_capture", 32'({bus.Aload, bus.Asel}), 32'b101);
        tick(1);
        chk("input_done", 32'({bus.state_dbg, bus.waiting, bus.inst_cnt}), 32'({4'd1, 1'b0, 8'd1}));

        // ADD then SUB.
        bus.IR75 = 3'd2;
        tick(2);
        chk("add_cycle", 32'({bus.state_dbg, bus.Asel, bus.Aload, bus.Sub}), 32'({4'd5, 2'b00, 1'b1, 1'b0}));
        bus.IR75 = 3'd3;
        tick(3);
        chk("sub_cycle", 32'({bus.state_dbg, bus.Aload, bus.Sub}), 32'({4'd6, 1'b1, 1'b1}));
        tick(1);
        chk("cnt_after_sub", 32'(bus.inst_cnt), 32'd3);

        // LOAD.
        bus.IR75 = 3'd0;
        tick(2);
        chk("load_cycle", 32'({bus.state_dbg, bus.Asel, bus.Aload, bus.Meminst}), 32'({4'd3, 2'b10, 1'b1, 1'b1}));
        tick(1);

        // JZ taken / not taken, JPOS taken / not taken.
        bus.IR75 = 3'd5; bus.Aeq0 = 1'b1;
        tick(2);
        chk("jz_taken", 32'({bus.JMPmux, bus.PCload}), 32'b11);
        tick(1);
        bus.Aeq0 = 1'b0;
        tick(2);
        chk("jz_not_taken", 32'({bus.JMPmux, bus.PCload}), 32'b00);
        tick(1);
        bus.IR75 = 3'd6; bus.Apos = 1'b1; bus.Aeq0 = 1'b0;
        tick(2);
        chk("jpos_taken", 32'({bus.JMPmux, bus.PCload}), 32'b11);
        tick(1);
        bus.Aeq0 = 1'b1;
        tick(2);
        chk("jpos_zero", 32'({bus.JMPmux, bus.PCload}), 32'b00);
        tick(1);
        chk("cnt_after_jumps", 32'(bus.inst_cnt), 32'd8);

        // STORE, then reset asserted in the middle of the write cycle.
        bus.IR75 = 3'd1;
        tick(2);
        chk("store_cycle", 32'({bus.MemWr, bus.Meminst, bus.state_dbg}), 32'({1'b1, 1'b1, 4'd4}));
        #1;
        clear = 1'b0;
        #1;
        chk("async_memwr", 32'(bus.MemWr), 32'd0);
        chk("async_state", 32'(bus.state_dbg), 32'd0);
        bus.IR75 = 3'd2;
        tick(1);
        clear = 1'b1;

        // Four ADDs then HALT; count frozen while halted.
        tick(1 + 3 * 4);
        chk("cnt_four_adds", 32'(bus.inst_cnt), 32'd4);
        bus.IR75 = 3'd7;
        tick(2);
        chk("halt_enter", 32'({bus.state_dbg, bus.halted}), 32'({4'd10, 1'b1}));
        for (int i = 0; i < 20; i++) begin
            tick(1);
            chk("halt_hold", 32'({bus.halted, bus.state_dbg, bus.inst_cnt, bus.Aload, bus.PCload, bus.MemWr}),
                32'({1'b1, 4'd10, 8'd4, 3'b000}));
        end

        // Saturation after more than 255 retirements.
        clear = 1'b0;
        bus.IR75 = 3'd2;
        tick(1);
        clear = 1'b1;
        tick(1 + 3 * 260);
        chk("cnt_saturated", 32'(bus.inst_cnt), 32'hFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
